// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback beats a small FIFO of
// multi-cycle results, which beats a direct bypass of a fresh multi-cycle result.
module wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        WB_RegWrite_In,
  input  logic [4:0]  WB_Dest_In,
  input  logic [31:0] WB_Data_In,
  input  logic        MC_Valid_In,
  input  logic [4:0]  MC_Dest_In,
  input  logic [31:0] MC_Data_In,
  output logic        MC_Ready_Out,
  input  logic [4:0]  Query_Addr_In,
  output logic        Pending_Hit_Out,
  output logic        RF_WriteEn_Out,
  output logic [4:0]  RF_WriteAddr_Out,
  output logic [31:0] RF_WriteData_Out,
  output logic        Stall_Out,
  output logic [2:0]  Pending_Count_Out
);

  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [2:0]          DEPTH_C    = 3'(DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [4:0]          dest_r [DEPTH];
  logic [31:0]         data_r [DEPTH];
  logic [DEPTH-1:0]    valid_r;
  logic [PTR_W-1:0]    head_r;
  logic [PTR_W-1:0]    tail_r;
  logic [2:0]          count_r;
  logic [STARVE_W-1:0] starve_r;
  logic                rf_en_r;
  logic [4:0]          rf_addr_r;
  logic [31:0]         rf_data_r;

  logic        pipe_win_s;
  logic        mc_ready_s;
  logic        mc_live_s;
  logic        pop_s;
  logic        push_s;
  logic        bypass_s;
  logic        win_s;
  logic [4:0]  win_addr_s;
  logic [31:0] win_data_s;
  logic        hit_s;
  logic        stall_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = ptr + PTR_W'(1);
    end
  endfunction

  // Arbitration: decide pop/push/bypass and select the winning write.
  always_comb begin
    pipe_win_s = WB_RegWrite_In && (WB_Dest_In != 5'd0);
    mc_ready_s = Reset_n && (count_r < DEPTH_C);
    // A zero-destination transfer is consumed but never written or buffered.
    mc_live_s  = MC_Valid_In && mc_ready_s && (MC_Dest_In != 5'd0);
    pop_s      = !pipe_win_s && (count_r != 3'd0);
    // Bypass only from an empty buffer so older results cannot be overtaken.
    bypass_s   = !pipe_win_s && (count_r == 3'd0) && mc_live_s;
    push_s     = mc_live_s && !bypass_s;
    win_s      = 1'b0;
    win_addr_s = 5'd0;
    win_data_s = 32'd0;
    if (pipe_win_s) begin
      win_s      = 1'b1;
      win_addr_s = WB_Dest_In;
      win_data_s = WB_Data_In;
    end else if (pop_s) begin
      win_s      = 1'b1;
      win_addr_s = dest_r[head_r];
      win_data_s = data_r[head_r];
    end else if (bypass_s) begin
      win_s      = 1'b1;
      win_addr_s = MC_Dest_In;
      win_data_s = MC_Data_In;
    end else begin
      win_s      = 1'b0;
    end
  end

  // Pending-write lookup and stall request.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (valid_r[i] & (dest_r[i] == Query_Addr_In));
    end
    hit_s   = hit_s & (Query_Addr_In != 5'd0);
    stall_s = (starve_r == STARVE_MAX) || ((count_r == DEPTH_C) && MC_Valid_In);
  end

  // Write-port register and result buffer state.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rf_en_r   <= 1'b0;
      rf_addr_r <= 5'd0;
      rf_data_r <= 32'd0;
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= 3'd0;
      starve_r  <= '0;
      valid_r   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_r[i] <= 5'd0;
        data_r[i] <= 32'd0;
      end
    end else begin
      rf_en_r <= win_s;
      if (win_s) begin
        rf_addr_r <= win_addr_s;
        rf_data_r <= win_data_s;
      end
      if (push_s) begin
        dest_r[tail_r]  <= MC_Dest_In;
        data_r[tail_r]  <= MC_Data_In;
        valid_r[tail_r] <= 1'b1;
        tail_r          <= next_ptr(tail_r);
      end
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= next_ptr(head_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
      if (pop_s || (count_r == 3'd0)) begin
        starve_r <= '0;
      end else if (pipe_win_s && (starve_r != STARVE_MAX)) begin
        starve_r <= starve_r + STARVE_W'(1);
      end
    end
  end

  assign MC_Ready_Out      = mc_ready_s;
  assign Pending_Hit_Out   = hit_s;
  assign Stall_Out         = stall_s;
  assign Pending_Count_Out = count_r;
  assign RF_WriteEn_Out    = rf_en_r;
  assign RF_WriteAddr_Out  = rf_addr_r;
  assign RF_WriteData_Out  = rf_data_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scenario bench for wb_arbiter: expected RF writes are queued as stimulus is
// driven and popped one cycle later when the registered outputs appear.
module tb_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        WB_RegWrite_In = 1'b0;
  logic [4:0]  WB_Dest_In = 5'd0;
  logic [31:0] WB_Data_In = 32'd0;
  logic        MC_Valid_In = 1'b0;
  logic [4:0]  MC_Dest_In = 5'd0;
  logic [31:0] MC_Data_In = 32'd0;
  logic [4:0]  Query_Addr_In = 5'd0;
  logic        MC_Ready_Out;
  logic        Pending_Hit_Out;
  logic        RF_WriteEn_Out;
  logic [4:0]  RF_WriteAddr_Out;
  logic [31:0] RF_WriteData_Out;
  logic        Stall_Out;
  logic [2:0]  Pending_Count_Out;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .WB_RegWrite_In(WB_RegWrite_In), .WB_Dest_In(WB_Dest_In), .WB_Data_In(WB_Data_In),
    .MC_Valid_In(MC_Valid_In), .MC_Dest_In(MC_Dest_In), .MC_Data_In(MC_Data_In),
    .MC_Ready_Out(MC_Ready_Out), .Query_Addr_In(Query_Addr_In),
    .Pending_Hit_Out(Pending_Hit_Out), .RF_WriteEn_Out(RF_WriteEn_Out),
    .RF_WriteAddr_Out(RF_WriteAddr_Out), .RF_WriteData_Out(RF_WriteData_Out),
    .Stall_Out(Stall_Out), .Pending_Count_Out(Pending_Count_Out)
  );

  always #5 Clk = ~Clk;

  task automatic drive(input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                       input logic mv, input logic [4:0] md, input logic [31:0] mdat);
    WB_RegWrite_In = we;
    WB_Dest_In     = wd;
    WB_Data_In     = wdat;
    MC_Valid_In    = mv;
    MC_Dest_In     = md;
    MC_Data_In     = mdat;
  endtask

  task automatic test_reset();
    wr_t e;
    Reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    Query_Addr_In = 5'd9;
    #1;
    checks++;
    if (MC_Ready_Out !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %0b exp 0", MC_Ready_Out);
    end
    @(posedge Clk); #1;
    checks++;
    if ({RF_WriteEn_Out, RF_WriteAddr_Out, RF_WriteData_Out, Pending_Count_Out, Stall_Out, Pending_Hit_Out} !== 42'd0) begin
      errors++;
      $display("FAIL reset_state got en=%0b addr=%0d data=%h cnt=%0d stall=%0b hit=%0b exp all 0",
               RF_WriteEn_Out, RF_WriteAddr_Out, RF_WriteData_Out, Pending_Count_Out, Stall_Out, Pending_Hit_Out);
    end
    Reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    exp_q.push_back('{1'b0, 5'd0, 32'd0});
    @(posedge Clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (RF_WriteEn_Out !== e.en || Pending_Count_Out !== 3'd0 || MC_Ready_Out !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got en=%0b cnt=%0d rdy=%0b exp en=0 cnt=0 rdy=1",
               RF_WriteEn_Out, Pending_Count_Out, MC_Ready_Out);
    end
  endtask

  task automatic test_pipeline();
    wr_t e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        exp_q.push_back('{1'b1, 5'd5, 32'hDEADBEEF});
      end else begin
        drive(1'b0, 5'd6, 32'h1111, 1'b0, 5'd0, 32'd0);
        exp_q.push_back('{1'b0, 5'd5, 32'hDEADBEEF});
      end
      @(posedge Clk); #1;
      e = exp_q.pop_front();
      checks++;
      // Idle cycles must also hold the previous address and data.
      if (RF_WriteEn_Out !== e.en || RF_WriteAddr_Out !== e.addr || RF_WriteData_Out !== e.data) begin
        errors++;
        $display("FAIL pipeline[%0d] got en=%0b addr=%0d data=%h exp en=%0b addr=%0d data=%h",
                 i, RF_WriteEn_Out, RF_WriteAddr_Out, RF_WriteData_Out, e.en, e.addr, e.data);
      end
    end
  endtask

  task automatic test_bypass();
    wr_t e;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h12);
    exp_q.push_back('{1'b1, 5'd9, 32'h12});
    @(posedge Clk); #1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    e = exp_q.pop_front();
    checks++;
    if (RF_WriteEn_Out !== e.en || RF_WriteAddr_Out !== e.addr || RF_WriteData_Out !== e.data ||
        Pending_Count_Out !== 3'd0) begin
      errors++;
      $display("FAIL bypass got en=%0b addr=%0d data=%h cnt=%0d exp en=1 addr=9 data=12 cnt=0",
               RF_WriteEn_Out, RF_WriteAddr_Out, RF_WriteData_Out, Pending_Count_Out);
    end
  endtask

  task automatic test_conflict();
    wr_t e;
    logic       we_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       mv_t  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] md_t  [4] = '{5'd7, 5'd8, 5'd10, 5'd0};
    logic [2:0] cnt_t [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
    logic       rdy_t [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    wr_t        wr_t_tab [4] = '{'{1'b1, 5'd3, 32'h30}, '{1'b1, 5'd3, 32'h31},
                                 '{1'b1, 5'd7, 32'hA}, '{1'b1, 5'd8, 32'hB}};
    Query_Addr_In = 5'd7;
    for (int i = 0; i < 4; i++) begin
      drive(we_t[i], 5'd3, 32'h30 + 32'(i), mv_t[i], md_t[i], (i == 0) ? 32'hA : ((i == 1) ? 32'hB : 32'hC));
      if (i == 2) begin
        #1;
        checks++;
        if (Stall_Out !== 1'b1) begin
          errors++; $display("FAIL full_stall got %0b exp 1", Stall_Out);
        end
      end
      exp_q.push_back(wr_t_tab[i]);
      @(posedge Clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (RF_WriteEn_Out !== e.en || RF_WriteAddr_Out !== e.addr || RF_WriteData_Out !== e.data) begin
        errors++;
        $display("FAIL conflict_rf[%0d] got en=%0b addr=%0d data=%h exp en=%0b addr=%0d data=%h",
                 i, RF_WriteEn_Out, RF_WriteAddr_Out, RF_WriteData_Out, e.en, e.addr, e.data);
      end
      checks++;
      if (Pending_Count_Out !== cnt_t[i] || MC_Ready_Out !== rdy_t[i]) begin
        errors++;
        $display("FAIL conflict_cnt[%0d] got cnt=%0d rdy=%0b exp cnt=%0d rdy=%0b",
                 i, Pending_Count_Out, MC_Ready_Out, cnt_t[i], rdy_t[i]);
      end
      if (i == 0) begin
        checks++;
        if (Pending_Hit_Out !== 1'b1) begin
          errors++; $display("FAIL hit_reg7 got %0b exp 1", Pending_Hit_Out);
        end
      end
    end
    checks++;
    if (Pending_Hit_Out !== 1'b0) begin
      errors++; $display("FAIL hit_after_drain got %0b exp 0", Pending_Hit_Out);
    end
  endtask

  task automatic test_starvation();
    wr_t e;
    logic stall_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        drive(1'b1, 5'd3, 32'h100, 1'b1, 5'd12, 32'hC);
        exp_q.push_back('{1'b1, 5'd3, 32'h100});
      end else if (i < 6) begin
        drive(1'b1, 5'd3, 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
        exp_q.push_back('{1'b1, 5'd3, 32'h100 + 32'(i)});
      end else begin
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        exp_q.push_back('{1'b1, 5'd12, 32'hC});
      end
      @(posedge Clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (RF_WriteEn_Out !== e.en || RF_WriteAddr_Out !== e.addr || RF_WriteData_Out !== e.data) begin
        errors++;
        $display("FAIL starve_rf[%0d] got en=%0b addr=%0d data=%h exp en=%0b addr=%0d data=%h",
                 i, RF_WriteEn_Out, RF_WriteAddr_Out, RF_WriteData_Out, e.en, e.addr, e.data);
      end
      checks++;
      if (Stall_Out !== stall_t[i]) begin
        errors++;
        $display("FAIL starve_stall[%0d] got %0b exp %0b", i, Stall_Out, stall_t[i]);
      end
    end
  endtask

  task automatic test_zero_reg();
    wr_t e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin
          drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD);
          exp_q.push_back('{1'b0, 5'd12, 32'hC});
        end
        1: begin
          drive(1'b1, 5'd3, 32'h200, 1'b1, 5'd4, 32'h44);
          exp_q.push_back('{1'b1, 5'd3, 32'h200});
        end
        default: begin
          drive(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0);
          exp_q.push_back('{1'b1, 5'd4, 32'h44});
        end
      endcase
      @(posedge Clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (RF_WriteEn_Out !== e.en || RF_WriteAddr_Out !== e.addr || RF_WriteData_Out !== e.data) begin
        errors++;
        $display("FAIL zero_rf[%0d] got en=%0b addr=%0d data=%h exp en=%0b addr=%0d data=%h",
                 i, RF_WriteEn_Out, RF_WriteAddr_Out, RF_WriteData_Out, e.en, e.addr, e.data);
      end
      checks++;
      if (Pending_Count_Out !== ((i == 1) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL zero_cnt[%0d] got %0d exp %0d", i, Pending_Count_Out, (i == 1) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    wr_t e;
    drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd20, 32'h14);
    @(posedge Clk); #1;
    drive(1'b1, 5'd3, 32'h301, 1'b1, 5'd21, 32'h15);
    @(posedge Clk); #1;
    Query_Addr_In = 5'd21;
    #1;
    checks++;
    if (Pending_Count_Out !== 3'd2 || Pending_Hit_Out !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill got cnt=%0d hit=%0b exp cnt=2 hit=1", Pending_Count_Out, Pending_Hit_Out);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    Reset_n = 1'b0;
    exp_q.push_back('{1'b0, 5'd0, 32'd0});
    @(posedge Clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (RF_WriteEn_Out !== e.en || RF_WriteAddr_Out !== e.addr || RF_WriteData_Out !== e.data ||
        Pending_Count_Out !== 3'd0 || Pending_Hit_Out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got en=%0b addr=%0d data=%h cnt=%0d hit=%0b exp all 0",
               RF_WriteEn_Out, RF_WriteAddr_Out, RF_WriteData_Out, Pending_Count_Out, Pending_Hit_Out);
    end
    Query_Addr_In = 5'd20;
    #1;
    checks++;
    if (Pending_Hit_Out !== 1'b0) begin
      errors++; $display("FAIL mid_hit20 got %0b exp 0", Pending_Hit_Out);
    end
    Reset_n = 1'b1;
    exp_q.push_back('{1'b0, 5'd0, 32'd0});
    @(posedge Clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (RF_WriteEn_Out !== e.en || Pending_Count_Out !== 3'd0 || Stall_Out !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got en=%0b cnt=%0d stall=%0b exp en=0 cnt=0 stall=0",
               RF_WriteEn_Out, Pending_Count_Out, Stall_Out);
    end
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_bypass();
    test_conflict();
    test_starvation();
    test_zero_reg();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
